uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter and its data holding register between `N_REQ` byte producers. It picks one pending requester, loads that requester's byte into the holding register through its enable input, pulses the transmitter start, and waits for the transmitter's done tick before arbitrating again. It sits between the client blocks and the `register` + transmitter pair on the TX path.

## Interface
- `D_BIT`, 8, data width of each requester byte and of the holding register.
- `N_REQ`, 4, number of requesters, legal range 2..8.
- `G_W`, `$clog2(N_REQ)`, width of the grant index (localparam).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester request, level; bit i high means requester i has a byte pending.
- `din`  in  N_REQ*D_BIT  flattened request data; requester i owns bits [i*D_BIT +: D_BIT].
- `ack`  out  N_REQ  one-hot, one-cycle pulse when requester i's byte is loaded.
- `reg_en`  out  1  enable to the holding register; one-cycle pulse.
- `reg_d`  out  D_BIT  data to the holding register, equal to the `din` slice selected by `grant_id`.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_done_tick`  in  1  one-cycle pulse from the transmitter when the frame is complete.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `grant_id`  out  G_W  index of the current or last granted requester.

## Operation
- FSM states: IDLE, LOAD, START, WAIT.
- Arbiter state: `last` (G_W bits) holds the last requester that completed a frame. Search order is `last+1, last+2, …` modulo N_REQ, wrapping from N_REQ-1 to 0.
- IDLE:
  - If `req` is nonzero, latch the first set bit in search order into `grant_id` and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - If `req[grant_id]` is high, assert `reg_en` and `ack[grant_id]` for this cycle and go to START.
  - If `req[grant_id]` has dropped, the request is abandoned: no `reg_en`, no `ack`, `last` is unchanged, and the FSM returns to IDLE.
- START: assert `tx_start` for one cycle, then go to WAIT.
- WAIT:
  - Stay in WAIT until `tx_done_tick`.
  - On `tx_done_tick`, set `last <= grant_id` and go to IDLE.
- `tx_done_tick` is ignored in every state other than WAIT.
- `reg_d` is a combinational mux of `din` by `grant_id`. It is guaranteed valid only while `reg_en` is high.
- Requester contract:
  - Hold `req` high and `din` stable until `ack`.
  - Drop `req` the cycle after `ack` unless another byte is pending.
  - `req` high in the IDLE cycle after the same requester's WAIT counts as a new request.
- Reset values: FSM IDLE; `last` = N_REQ-1, so requester 0 has first priority; `grant_id` = 0; `ack`, `reg_en`, `tx_start`, `busy` = 0.
- Reset asserted mid-operation returns the FSM to IDLE immediately, with all outputs at their reset values. A frame already started in the transmitter is not aborted by this block.

## Timing
- Cycle 0: IDLE, `req` sampled.
- Cycle 1: LOAD; `reg_en` and `ack` high; the holding register captures `reg_d` at the end of cycle 1.
- Cycle 2: START; `tx_start` high. The holding register output is already valid.
- Cycle 3 onward: WAIT. If `tx_done_tick` occurs in cycle k, the FSM is in IDLE at k+1, the next LOAD is at k+2, and the next `tx_start` is at k+3.
- `busy` is high from cycle 1 through cycle k inclusive.
- Every output pulse is exactly one cycle wide. At most one `ack` bit is high in any cycle.
- Starvation bound: a continuously requesting client is granted within N_REQ-1 frames of other clients.

## Test plan
- Reset, then `req`=4'b0001 with `din[7:0]`=8'hA5:
  - `ack`=4'b0001 and `reg_en` with `reg_d`=8'hA5 in cycle 1.
  - `tx_start` in cycle 2.
  - `tx_done_tick` 20 cycles later returns `busy` to 0.
- All four requests held high with bytes 8'h10, 8'h21, 8'h32, 8'h43: grants occur in order 0, 1, 2, 3, 0, and the holding register `q` shows 8'h10, 8'h21, 8'h32, 8'h43 in sequence.
- With `last`=3, requests on 1 and 3 only: requester 1 is granted first, then 3, then 1 again (wrap-around).
- `req[2]` is dropped in the LOAD cycle: no `ack`, no `reg_en`, no `tx_start`; IDLE the next cycle; `last` unchanged.
- Spurious `tx_done_tick` in IDLE and in START: the FSM is unaffected; `tx_start` still pulses once per frame.
- Reset pulsed low while in WAIT: `busy`, `ack`, `reg_en`, `tx_start` are all 0 asynchronously, and after release requester 0 wins a tie with requester 3.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter and its holding register
// between N_REQ byte producers. One frame at a time: pick a requester, load
// its byte into the holding register, pulse tx start, wait for tx done.
module uart_tx_arbiter #(
    parameter  int D_BIT = 8,
    parameter  int N_REQ = 4,
    localparam int G_W   = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*D_BIT-1:0] din_i,
    output logic [N_REQ-1:0]       ack_o,
    output logic                   reg_en_o,
    output logic [D_BIT-1:0]       reg_d_o,
    output logic                   tx_start_o,
    input  logic                   tx_done_tick_i,
    output logic                   busy_o,
    output logic [G_W-1:0]         grant_id_o
);

    // One extra bit so last+k (k up to N_REQ) never overflows before the wrap.
    localparam int S_W = G_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [G_W-1:0] last_q, last_d;
    logic [G_W-1:0] grant_q, grant_d;

    logic           found;
    logic [G_W-1:0] pick;
    logic [S_W-1:0] sum;
    logic           req_granted;

    // Granted requester still asking in LOAD: byte is accepted this cycle.
    assign req_granted = req_i[grant_q];

    // Round-robin search: first pending requester after last, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sum = {1'b0, last_q} + S_W'(k);
            if (sum >= S_W'(N_REQ)) begin
                sum = sum - S_W'(N_REQ);
            end
            if (!found && req_i[sum[G_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[G_W-1:0];
            end
        end
    end

    // State register; last starts at N_REQ-1 so requester 0 has first priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            last_q  <= G_W'(N_REQ - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic; last only advances once a frame has fully completed.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A dropped request is abandoned without touching last.
                state_d = req_granted ? ST_START : ST_IDLE;
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_tick_i) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: single-cycle pulses derived from the one-cycle states.
    always_comb begin
        reg_en_o   = (state_q == ST_LOAD) && req_granted;
        tx_start_o = (state_q == ST_START);
        busy_o     = (state_q != ST_IDLE);
        ack_o      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack_o[i] = reg_en_o && (grant_q == G_W'(i));
        end
    end

    assign reg_d_o    = din_i[grant_q*D_BIT +: D_BIT];
    assign grant_id_o = grant_q;

endmodule
